// File: rtl/m_controller_pkg.sv
// Shared definitions for the M-extension controller: datapath select codes,
// RV32M operation encoding and FSM state type.
package m_controller_pkg;

  localparam int unsigned MUX_A_LENGTH = 2;
  localparam int unsigned MUX_B_LENGTH = 2;
  localparam int unsigned MUX_R_LENGTH = 3;
  localparam int unsigned MUX_D_LENGTH = 2;
  localparam int unsigned MUX_Z_LENGTH = 2;

  localparam logic [MUX_A_LENGTH-1:0] MUX_A_KEEP       = 2'd0;
  localparam logic [MUX_A_LENGTH-1:0] MUX_A_R_SIGNED   = 2'd1;
  localparam logic [MUX_A_LENGTH-1:0] MUX_A_R_UNSIGNED = 2'd2;

  localparam logic [MUX_B_LENGTH-1:0] MUX_B_KEEP       = 2'd0;
  localparam logic [MUX_B_LENGTH-1:0] MUX_B_D_SIGNED   = 2'd1;
  localparam logic [MUX_B_LENGTH-1:0] MUX_B_D_UNSIGNED = 2'd2;

  localparam logic [MUX_R_LENGTH-1:0] MUX_R_KEEP       = 3'd0;
  localparam logic [MUX_R_LENGTH-1:0] MUX_R_A          = 3'd1;
  localparam logic [MUX_R_LENGTH-1:0] MUX_R_A_NEG      = 3'd2;
  localparam logic [MUX_R_LENGTH-1:0] MUX_R_SUB_KEEP   = 3'd3;
  localparam logic [MUX_R_LENGTH-1:0] MUX_R_MULT_LOWER = 3'd4;

  localparam logic [MUX_D_LENGTH-1:0] MUX_D_KEEP       = 2'd0;
  localparam logic [MUX_D_LENGTH-1:0] MUX_D_B          = 2'd1;
  localparam logic [MUX_D_LENGTH-1:0] MUX_D_B_NEG      = 2'd2;
  localparam logic [MUX_D_LENGTH-1:0] MUX_D_SHR        = 2'd3;

  localparam logic [MUX_Z_LENGTH-1:0] MUX_Z_KEEP       = 2'd0;
  localparam logic [MUX_Z_LENGTH-1:0] MUX_Z_ZERO       = 2'd1;
  localparam logic [MUX_Z_LENGTH-1:0] MUX_Z_SHL_ADD    = 2'd2;
  localparam logic [MUX_Z_LENGTH-1:0] MUX_Z_MULT_UPPER = 2'd3;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    MUL_AB,
    MUL_WAIT,
    MUL_WB,
    DIV_STEP,
    DONE
  } state_e;

endpackage

// File: rtl/m_controller.sv
// Sequencing FSM for the RV32M unit: drives datapath selects for operand load,
// multiply staging/writeback and 32-step restoring division.
module m_controller
  import m_controller_pkg::*;
#(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              funct3,
  input  logic                    rs1_sign,
  input  logic                    rs2_sign,
  input  logic                    rs2_zero,
  input  logic                    sub_neg,
  output logic [MUX_A_LENGTH-1:0] mux_A,
  output logic [MUX_B_LENGTH-1:0] mux_B,
  output logic [MUX_R_LENGTH-1:0] mux_R,
  output logic [MUX_D_LENGTH-1:0] mux_D,
  output logic [MUX_Z_LENGTH-1:0] mux_Z,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    res_sel,
  output logic                    res_neg
);

  localparam logic [4:0] WAIT_INIT = (MUL_LAT > 0) ? 5'(MUL_LAT - 1) : '0;

  state_e     state, state_n;
  op_e        op, op_n, in_op;
  logic [4:0] count, count_n;
  logic       sel_q, sel_n, neg_q, neg_n;
  logic       signed_div;
  logic [MUX_A_LENGTH-1:0] a_code;
  logic [MUX_B_LENGTH-1:0] b_code;

  // The subtractor sign steers the datapath directly; the FSM never branches on it.
  logic unused_sub_neg;
  assign unused_sub_neg = sub_neg;

  assign in_op      = op_e'(funct3);
  assign signed_div = (in_op == OP_DIV) || (in_op == OP_REM);
  assign a_code     = (op == OP_MUL || op == OP_MULH || op == OP_MULHSU) ? MUX_A_R_SIGNED : MUX_A_R_UNSIGNED;
  assign b_code     = (op == OP_MUL || op == OP_MULH) ? MUX_B_D_SIGNED : MUX_B_D_UNSIGNED;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      op    <= OP_MUL;
      sel_q <= 1'b0;
      neg_q <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      op    <= op_n;
      sel_q <= sel_n;
      neg_q <= neg_n;
    end
  end

  always_comb begin
    state_n   = state;
    count_n   = count;
    op_n      = op;
    sel_n     = sel_q;
    neg_n     = neg_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    mux_A     = MUX_A_KEEP;
    mux_B     = MUX_B_KEEP;
    mux_R     = MUX_R_KEEP;
    mux_D     = MUX_D_KEEP;
    mux_Z     = MUX_Z_KEEP;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          op_n  = in_op;
          sel_n = funct3[2] ? !funct3[1] : (funct3[1:0] != 2'b00);
          neg_n = ((in_op == OP_DIV) && (rs1_sign ^ rs2_sign) && !rs2_zero) ||
                  ((in_op == OP_REM) && rs1_sign);
          if (!funct3[2]) begin
            mux_R   = MUX_R_A;
            mux_D   = MUX_D_B;
            state_n = MUL_AB;
          end else begin
            mux_R   = (signed_div && rs1_sign) ? MUX_R_A_NEG : MUX_R_A;
            mux_D   = (signed_div && rs2_sign) ? MUX_D_B_NEG : MUX_D_B;
            mux_Z   = MUX_Z_ZERO;
            count_n = 5'd31;
            state_n = DIV_STEP;
          end
        end
      end
      MUL_AB: begin
        mux_A = a_code;
        mux_B = b_code;
        if (MUL_LAT > 0) begin
          count_n = WAIT_INIT;
          state_n = MUL_WAIT;
        end else begin
          state_n = MUL_WB;
        end
      end
      MUL_WAIT: begin
        if (count == '0) state_n = MUL_WB;
        else             count_n = count - 5'd1;
      end
      MUL_WB: begin
        mux_A   = a_code;
        mux_B   = b_code;
        mux_R   = MUX_R_MULT_LOWER;
        mux_Z   = MUX_Z_MULT_UPPER;
        state_n = DONE;
      end
      DIV_STEP: begin
        mux_R = MUX_R_SUB_KEEP;
        mux_Z = MUX_Z_SHL_ADD;
        mux_D = MUX_D_SHR;
        if (count == '0) state_n = DONE;
        else             count_n = count - 5'd1;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Reset overrides the IDLE handshake so nothing is loaded or offered while held.
    if (reset) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      mux_A     = MUX_A_KEEP;
      mux_B     = MUX_B_KEEP;
      mux_R     = MUX_R_KEEP;
      mux_D     = MUX_D_KEEP;
      mux_Z     = MUX_Z_KEEP;
    end
  end

  assign res_sel = sel_q;
  assign res_neg = neg_q;

endmodule

// File: tb/tb_m_controller.sv
// Bench for m_controller: behavioural datapath, pipelined multiplier and
// subtractor around the FSM, with core-side result select and sign fix.
module tb_m_controller;
  import m_controller_pkg::*;

  localparam int MUL_LAT = 2;
  localparam int PIDX    = (MUL_LAT > 0) ? MUL_LAT - 1 : 0;

  logic clk, reset, in_valid, in_ready, out_valid, out_ready, res_sel, res_neg;
  logic [2:0] funct3;
  logic rs1_sign, rs2_sign, rs2_zero, sub_neg;
  logic [MUX_A_LENGTH-1:0] mux_A;
  logic [MUX_B_LENGTH-1:0] mux_B;
  logic [MUX_R_LENGTH-1:0] mux_R;
  logic [MUX_D_LENGTH-1:0] mux_D;
  logic [MUX_Z_LENGTH-1:0] mux_Z;
  logic [31:0] op_a, op_b;

  m_controller #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .rs1_sign(rs1_sign), .rs2_sign(rs2_sign), .rs2_zero(rs2_zero),
    .sub_neg(sub_neg), .mux_A(mux_A), .mux_B(mux_B), .mux_R(mux_R), .mux_D(mux_D),
    .mux_Z(mux_Z), .out_valid(out_valid), .out_ready(out_ready),
    .res_sel(res_sel), .res_neg(res_neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model
  logic [63:0] r_reg, d_reg;
  logic [31:0] z_reg;
  logic signed [32:0] a_reg, b_reg;
  logic signed [65:0] prod, mult_out;
  logic signed [65:0] pipe [0:3];
  logic [31:0] core_sel, core_result;

  assign prod        = a_reg * b_reg;
  assign mult_out    = (MUL_LAT == 0) ? prod : pipe[PIDX];
  assign sub_neg     = r_reg < d_reg;
  assign core_sel    = res_sel ? z_reg : r_reg[31:0];
  assign core_result = res_neg ? -core_sel : core_sel;

  always @(posedge clk) begin
    pipe[0] <= prod;
    for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    case (mux_R)
      MUX_R_A:          r_reg <= {32'b0, op_a};
      MUX_R_A_NEG:      r_reg <= {32'b0, -op_a};
      MUX_R_SUB_KEEP:   if (!sub_neg) r_reg <= r_reg - d_reg;
      MUX_R_MULT_LOWER: r_reg <= {32'b0, mult_out[31:0]};
      default: ;
    endcase
    case (mux_D)
      MUX_D_B:     d_reg <= {1'b0, op_b, 31'b0};
      MUX_D_B_NEG: d_reg <= {1'b0, -op_b, 31'b0};
      MUX_D_SHR:   d_reg <= d_reg >> 1;
      default: ;
    endcase
    case (mux_Z)
      MUX_Z_ZERO:       z_reg <= '0;
      MUX_Z_SHL_ADD:    z_reg <= {z_reg[30:0], !sub_neg};
      MUX_Z_MULT_UPPER: z_reg <= mult_out[63:32];
      default: ;
    endcase
    case (mux_A)
      MUX_A_R_SIGNED:   a_reg <= {r_reg[31], r_reg[31:0]};
      MUX_A_R_UNSIGNED: a_reg <= {1'b0, r_reg[31:0]};
      default: ;
    endcase
    case (mux_B)
      MUX_B_D_SIGNED:   b_reg <= {d_reg[62], d_reg[62:31]};
      MUX_B_D_UNSIGNED: b_reg <= {1'b0, d_reg[62:31]};
      default: ;
    endcase
  end

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        sel;
    logic        neg;
    int          lat;
  } vec_t;

  vec_t vecs [13];
  vec_t sb [$];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic present(input vec_t v);
    funct3   = v.f3;
    op_a     = v.a;
    op_b     = v.b;
    rs1_sign = v.a[31];
    rs2_sign = v.b[31];
    rs2_zero = (v.b == 32'd0);
    in_valid = 1'b1;
  endtask

  // Called at the negedge of the acceptance cycle; waits for out_valid and scores it.
  task automatic await_result(input string name, input bit drop_valid);
    vec_t e;
    int   cyc;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      if (drop_valid) in_valid = 1'b0;
      @(negedge clk);
      cyc++;
    end while (!out_valid && cyc < 100);
    if (sb.size() == 0) begin
      chk({name, " scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({name, " latency"}, cyc, e.lat);
      chk({name, " res_sel"}, {31'b0, res_sel}, {31'b0, e.sel});
      chk({name, " res_neg"}, {31'b0, res_neg}, {31'b0, e.neg});
      chk({name, " result"}, core_result, e.res);
    end
  endtask

  task automatic run_vec(input int idx);
    string nm;
    nm = $sformatf("vec%0d", idx);
    @(posedge clk); #1;
    present(vecs[idx]);
    sb.push_back(vecs[idx]);
    @(negedge clk);
    chk({nm, " accept"}, {31'b0, in_ready}, 32'd1);
    await_result(nm, 1'b1);
    @(negedge clk);
    chk({nm, " release"}, {30'b0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    int seen;
    logic held_sel, held_neg;
    logic [31:0] held_res;

    vecs[0]  = '{3'b000, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 1'b0, 3 + MUL_LAT};
    vecs[1]  = '{3'b001, 32'h80000000,   32'h80000000, 32'h40000000, 1'b1, 1'b0, 3 + MUL_LAT};
    vecs[2]  = '{3'b011, 32'hFFFFFFFF,   32'd2,        32'h00000001, 1'b1, 1'b0, 3 + MUL_LAT};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF,   32'd2,        32'hFFFFFFFF, 1'b1, 1'b0, 3 + MUL_LAT};
    vecs[4]  = '{3'b100, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 1'b1, 1'b1, 33};
    vecs[5]  = '{3'b110, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 1'b0, 1'b1, 33};
    vecs[6]  = '{3'b101, 32'd5,          32'd0,        32'hFFFFFFFF, 1'b1, 1'b0, 33};
    vecs[7]  = '{3'b110, 32'hFFFFFFFB,   32'd0,        32'hFFFFFFFB, 1'b0, 1'b1, 33};
    vecs[8]  = '{3'b100, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b0, 33};
    vecs[9]  = '{3'b110, 32'h80000000,   32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 33};
    vecs[10] = '{3'b111, 32'd100,        32'd7,        32'd2,        1'b0, 1'b0, 33};
    vecs[11] = '{3'b000, 32'd12345,      32'd1000,     32'd12345000, 1'b0, 1'b0, 3 + MUL_LAT};
    vecs[12] = '{3'b100, 32'd100,        32'hFFFFFFF9, 32'hFFFFFFF2, 1'b1, 1'b1, 33};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    funct3 = '0; op_a = '0; op_b = '0; rs1_sign = 1'b0; rs2_sign = 1'b0; rs2_zero = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", {31'b0, in_ready}, 32'd0);
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset res_flags", {30'b0, res_sel, res_neg}, 32'd0);
    chk("reset selects", {21'b0, mux_A, mux_B, mux_R, mux_D, mux_Z}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset in_ready", {31'b0, in_ready}, 32'd1);

    for (int i = 0; i < 13; i++) run_vec(i);

    // Reset in the tenth DIV_STEP cycle abandons the divide.
    @(posedge clk); #1;
    present(vecs[4]);
    @(negedge clk);
    chk("abort accept", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort in_ready", {31'b0, in_ready}, 32'd1);
    chk("abort selects", {21'b0, mux_A, mux_B, mux_R, mux_D, mux_Z}, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort no out_valid", seen, 32'd0);
    run_vec(0);

    // Core stalls in DONE while another request is already waiting.
    @(posedge clk); #1;
    out_ready = 1'b0;
    present(vecs[2]);
    sb.push_back(vecs[2]);
    sb.push_back(vecs[2]);
    @(negedge clk);
    chk("stall accept", {31'b0, in_ready}, 32'd1);
    await_result("stall first", 1'b0);
    held_sel = res_sel; held_neg = res_neg; held_res = core_result;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("stall hold%0d", i),
          {28'b0, out_valid, in_ready, res_sel, res_neg}, {28'b0, 1'b1, 1'b0, held_sel, held_neg});
      chk($sformatf("stall result%0d", i), core_result, held_res);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall done_no_accept", {30'b0, out_valid, in_ready}, 32'd2);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall idle_accept", {30'b0, out_valid, in_ready}, 32'd1);
    await_result("stall second", 1'b1);
    @(negedge clk);
    chk("stall release", {30'b0, out_valid, in_ready}, 32'd1);

    chk("scoreboard drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/m_controller.md
# m_controller

Sequencing FSM for the M-extension unit. It accepts one RV32M operation at a time from the core and issues per-cycle select codes to the M datapath register block. Those codes cover operand load, ALU operand staging, multiply writeback and 32-step restoring division. It consumes the subtractor sign, then hands the core a result-select and sign-fix indication through a valid/ready pair. It sits between the core's execute stage and the M datapath, and is the only driver of the datapath's select inputs.

## Interface
- MUL_LAT, 2, cycles from A/B registered to alu_out valid (legal 0..3)
- clk  in  1  clock
- reset  in  1  one clock; reset is synchronous and active-high
- in_valid  in  1  operation offered
- in_ready  out  1  controller idle, can accept
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_sign, rs2_sign  in  1  bit 31 of rs1 and rs2, sampled on acceptance
- rs2_zero  in  1  rs2 == 0, sampled on acceptance
- sub_neg  in  1  subtractor result negative (R < current 63-bit D)
- mux_A, mux_B, mux_R, mux_D, mux_Z  out  `MUX_*_LENGTH  datapath selects
- out_valid  out  1  result ready in datapath
- out_ready  in  1  core consumes result
- res_sel  out  1  0: take R, 1: take Z
- res_neg  out  1  core must two's-complement the selected word

## Operation
- States: IDLE, MUL_AB, MUL_WAIT, MUL_WB, DIV_STEP, DONE.
- Default selects in every state/cycle not listed: all *_KEEP.
- IDLE: in_ready=1. On in_valid (acceptance, cycle 0), latch funct3 and the flags, and drive load selects combinationally:
  - Multiply: mux_R=MUX_R_A, mux_D=MUX_D_B, then go to MUL_AB.
  - Divide: mux_R=MUX_R_A_NEG if signed op (DIV/REM) and rs1_sign, else MUX_R_A. mux_D=MUX_D_B_NEG if signed and rs2_sign, else MUX_D_B. mux_Z=MUX_Z_ZERO. Set count=31, then go to DIV_STEP.
- MUL_AB (1 cycle): mux_A=R_SIGNED for MUL/MULH/MULHSU, else R_UNSIGNED. mux_B=D_SIGNED for MUL/MULH, else D_UNSIGNED. Then go to MUL_WAIT if MUL_LAT>0, else MUL_WB.
- MUL_WAIT: mux_A/mux_B=KEEP for MUL_LAT cycles (count down). Then go to MUL_WB.
- MUL_WB (1 cycle): mux_R=MULT_LOWER, mux_Z=MULT_UPPER. mux_A/mux_B re-driven with the MUL_AB codes so the datapath picks the signed upper-word form. Then go to DONE.
- DIV_STEP: mux_R=SUB_KEEP, mux_Z=SHL_ADD, mux_D=SHR each cycle. Decrement count. When count==0, go to DONE (32 steps total).
- DONE: out_valid=1, with res_sel and res_neg held stable. On out_ready, go to IDLE.
- res_sel:
  - MUL: 0.
  - MULH/MULHSU/MULHU: 1.
  - DIV/DIVU: 1.
  - REM/REMU: 0.
- res_neg:
  - Multiply: 0.
  - DIV: rs1_sign ^ rs2_sign, forced 0 if rs2_zero (quotient stays 0xFFFFFFFF).
  - REM: rs1_sign (remainder equals rs1 on divide-by-zero).
  - DIVU/REMU: 0.
- Overflow case (0x80000000 / -1) needs no special path: the magnitude quotient is 0x80000000 with res_neg=0, and the remainder is 0.

## Timing
- Reset values:
  - Outputs: in_ready=0 while reset is high, 1 the cycle after. out_valid=0, res_sel=0, res_neg=0, all selects KEEP.
  - Internal: state=IDLE, count=0.
- Multiply latency: out_valid asserts in cycle 3+MUL_LAT after acceptance (cycle 5 at default).
- Divide latency: out_valid asserts in cycle 33 after acceptance.
- out_valid stays high until out_ready. If out_ready is already high when out_valid rises, the result completes in one cycle.
- in_ready=0 everywhere except IDLE. There is no accept in DONE, even with out_ready high; the next acceptance is earliest one cycle later.
- Reset mid-operation, including during DIV_STEP or DONE: IDLE on the next edge. No out_valid is ever produced for the abandoned operation.
- sub_neg is only examined through the datapath in DIV_STEP. The controller never branches on it.

## Structure
- Shared package/header m_definitions.svh holds:
  - all `MUX_*` codes and lengths;
  - a new funct3 op enum;
  - the FSM state typedef.
- Flat module. No sub-module. A single 5-bit counter is shared by MUL_WAIT and DIV_STEP.

## Test plan
Bench instantiates m_controller + datapath register block + behavioral signed 33x33 multiplier (MUL_LAT stages) + 63-bit subtractor, and applies the core-side sign fix.
- MUL 7 × -3 -> R=0xFFFFFFEB, res_sel=0, out_valid at cycle 5.
- MULH 0x80000000 × 0x80000000 -> Z=0x40000000. MULHU 0xFFFFFFFF × 2 -> Z=0x00000001. MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
- DIV -7/2 -> Z=3, res_neg=1 (result -3). REM -7/2 -> R=1, res_neg=1 (-1). out_valid at cycle 33.
- DIVU 5/0 -> 0xFFFFFFFF with res_neg=0. REM -5/0 -> -5. DIV 0x80000000 / -1 -> 0x80000000, REM 0.
- Reset at DIV_STEP cycle 10 -> next cycle IDLE, in_ready=1, selects KEEP, no out_valid. A fresh MUL then completes correctly.
- out_ready held low 4 cycles in DONE -> out_valid/res_sel/res_neg stable. A back-to-back in_valid is not accepted until IDLE.
